// File: rtl/systolic_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : systolic_job_arbiter
// Purpose  : Round-robin job arbiter in front of one shared systolic array,
//            with run timeout, invalid-result recovery and latency reporting.
// Revision : 1.0
// ============================================================================
module systolic_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int LAT_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic [NUM_REQ-1:0]         job_done,
    output logic [NUM_REQ-1:0]         job_error,
    output logic                       array_start,
    output logic                       array_rst_n,
    input  logic                       array_done,
    input  logic                       array_valid,
    output logic                       busy,
    output logic [LAT_W-1:0]           last_latency
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_err_second;
    logic [SEL_W-1:0]   r_owner;
    logic [SEL_W-1:0]   r_last_winner;
    logic [SEL_W-1:0]   w_pick;
    logic [SEL_W-1:0]   w_rr_idx;
    logic               w_rr_found;
    logic               w_any_req;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_run_cycles;
    logic               w_timeout;
    logic [LAT_W-1:0]   w_lat_sat;
    logic [SEL_W-1:0]   w_owner_nx;
    logic [NUM_REQ-1:0] w_owner_1h;

    logic [NUM_REQ-1:0] w_grant_d;
    logic [SEL_W-1:0]   w_sel_d;
    logic [NUM_REQ-1:0] w_done_d;
    logic [NUM_REQ-1:0] w_error_d;
    logic               w_start_d;
    logic               w_rst_n_d;
    logic               w_busy_d;
    logic [LAT_W-1:0]   w_lat_d;

    assign w_any_req = |req;

    // Round-robin: first requester found scanning upward from last_winner+1.
    always_comb begin
        w_rr_idx   = r_last_winner;
        w_rr_found = 1'b0;
        w_pick     = r_last_winner;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rr_idx = (w_rr_idx == LAST_IDX) ? '0 : w_rr_idx + 1'b1;
            if (!w_rr_found && req[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_pick     = w_rr_idx;
            end
        end
    end

    // r_cnt is zero outside RUN, so w_run_cycles is the 1-based RUN cycle index.
    assign w_run_cycles = r_cnt + 1'b1;
    assign w_timeout    = (w_run_cycles == CNT_W'(TIMEOUT_CYCLES));

    generate
        if (CNT_W > LAT_W) begin : g_lat_saturate
            assign w_lat_sat = (w_run_cycles > CNT_W'({LAT_W{1'b1}})) ?
                               {LAT_W{1'b1}} : w_run_cycles[LAT_W-1:0];
        end else begin : g_lat_direct
            assign w_lat_sat = LAT_W'(w_run_cycles);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_RUN) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_run_cycles;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_err_second  <= 1'b0;
            r_owner       <= '0;
            r_last_winner <= LAST_IDX;
        end else begin
            r_state      <= w_next;
            r_err_second <= (r_state == S_ERR) && !r_err_second;
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_pick;
            end
            if (r_state == S_RUN && w_next != S_RUN) begin
                r_last_winner <= r_owner;
            end
        end
    end

    // Next-state logic; array_done only matters while in RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_GRANT;
            S_GRANT: w_next = S_RUN;
            S_RUN: begin
                if (array_done) begin
                    w_next = array_valid ? S_DONE : S_ERR;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   if (r_err_second) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: values the output registers take on the coming edge.
    always_comb begin
        w_owner_nx = (r_state == S_IDLE) ? w_pick : r_owner;
        w_owner_1h = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_owner_1h[j] = (w_owner_nx == SEL_W'(j));
        end
        w_busy_d  = (w_next != S_IDLE);
        w_grant_d = w_busy_d ? w_owner_1h : '0;
        w_sel_d   = w_busy_d ? w_owner_nx : '0;
        w_start_d = (w_next == S_GRANT);
        w_done_d  = (w_next == S_DONE) ? w_owner_1h : '0;
        w_error_d = (w_next == S_ERR && r_state != S_ERR) ? w_owner_1h : '0;
        w_rst_n_d = (w_next != S_ERR);
        w_lat_d   = (r_state == S_RUN && w_next == S_DONE) ? w_lat_sat : last_latency;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= '0;
            sel          <= '0;
            job_done     <= '0;
            job_error    <= '0;
            array_start  <= 1'b0;
            array_rst_n  <= 1'b0;
            busy         <= 1'b0;
            last_latency <= '0;
        end else begin
            grant        <= w_grant_d;
            sel          <= w_sel_d;
            job_done     <= w_done_d;
            job_error    <= w_error_d;
            array_start  <= w_start_d;
            array_rst_n  <= w_rst_n_d;
            busy         <= w_busy_d;
            last_latency <= w_lat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_job_arbiter
// Purpose  : Self-checking bench: directed job table, corner sequences and
//            randomized jobs against a job-level round-robin model.
// Revision : 1.0
// ============================================================================
module tb_systolic_job_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 10000;
    localparam int LAT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic [3:0]       job_done;
    logic [3:0]       job_error;
    logic             array_start;
    logic             array_rst_n;
    logic             array_done;
    logic             array_valid;
    logic             busy;
    logic [LAT_W-1:0] last_latency;

    int checks = 0;
    int errors = 0;
    int mdl_last;
    int mdl_lat;

    typedef struct {
        logic [3:0] req;
        int         delay;      // RUN cycle carrying array_done; 0 = never (timeout)
        bit         valid;
        bit         drop;       // release req during GRANT
        logic [3:0] exp_grant;
        int         exp_lat;    // last_latency expected after the job
    } vec_t;

    vec_t vecs[13];

    systolic_job_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT),
        .LAT_W          (LAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .sel          (sel),
        .job_done     (job_done),
        .job_error    (job_error),
        .array_start  (array_start),
        .array_rst_n  (array_rst_n),
        .array_done   (array_done),
        .array_valid  (array_valid),
        .busy         (busy),
        .last_latency (last_latency)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner = first requester at or after last+1, modulo NUM_REQ.
    function automatic int rr_winner(input logic [3:0] r, input int last);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c;
            c = (last + i) % NUM_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic run_job(input logic [3:0] r, input int delay, input bit valid,
                           input bit drop, input logic [3:0] g, input int exp_lat,
                           input string tag);
        int w;
        int bad;
        int nrun;
        bit ok;
        w = 0;
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) w = i;
        ok = (delay != 0) && valid;
        req = r;
        step();
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " sel"}, 32'(sel), 32'(w));
        chk({tag, " start"}, 32'(array_start), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        if (drop) req = '0;
        array_done  = 1'b1;
        array_valid = 1'b0;
        bad  = 0;
        nrun = (delay == 0) ? TIMEOUT : delay;
        for (int k = 1; k <= nrun; k++) begin
            step();
            if (grant !== g || array_start !== 1'b0 || job_done !== 4'b0 ||
                job_error !== 4'b0 || busy !== 1'b1 || array_rst_n !== 1'b1) bad++;
            array_done  = (delay != 0) && (k == delay);
            array_valid = valid && array_done;
        end
        chk({tag, " run hold"}, 32'(bad), 32'd0);
        step();
        array_done  = 1'b1;
        array_valid = 1'b0;
        if (ok) begin
            chk({tag, " job_done"}, 32'(job_done), 32'(g));
            chk({tag, " job_error"}, 32'(job_error), 32'd0);
            chk({tag, " done grant"}, 32'(grant), 32'(g));
            chk({tag, " latency"}, 32'(last_latency), 32'(exp_lat));
            chk({tag, " done rst_n"}, 32'(array_rst_n), 32'd1);
        end else begin
            chk({tag, " job_error"}, 32'(job_error), 32'(g));
            chk({tag, " job_done"}, 32'(job_done), 32'd0);
            chk({tag, " err grant"}, 32'(grant), 32'(g));
            chk({tag, " err rst_n1"}, 32'(array_rst_n), 32'd0);
            chk({tag, " err latency"}, 32'(last_latency), 32'(exp_lat));
            step();
            chk({tag, " err2 error"}, 32'(job_error), 32'd0);
            chk({tag, " err2 rst_n"}, 32'(array_rst_n), 32'd0);
            chk({tag, " err2 grant"}, 32'(grant), 32'(g));
            chk({tag, " err2 busy"}, 32'(busy), 32'd1);
        end
        step();
        array_done = 1'b0;
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle grant"}, 32'(grant), 32'd0);
        chk({tag, " idle rst_n"}, 32'(array_rst_n), 32'd1);
        chk({tag, " idle pulses"}, 32'({job_done, job_error, 3'b0, array_start}), 32'd0);
        mdl_last = w;
        if (ok) mdl_lat = delay;
    endtask

    initial begin
        vecs[0]  = '{4'b1111,  10, 1'b1, 1'b0, 4'b0001,  10};
        vecs[1]  = '{4'b1111,  10, 1'b1, 1'b0, 4'b0010,  10};
        vecs[2]  = '{4'b1111,  10, 1'b1, 1'b0, 4'b0100,  10};
        vecs[3]  = '{4'b1111,  10, 1'b1, 1'b0, 4'b1000,  10};
        vecs[4]  = '{4'b1111,  10, 1'b1, 1'b0, 4'b0001,  10};
        vecs[5]  = '{4'b0001, 130, 1'b1, 1'b0, 4'b0001, 130};
        vecs[6]  = '{4'b0101,   5, 1'b0, 1'b0, 4'b0100, 130};
        vecs[7]  = '{4'b1001,   1, 1'b1, 1'b1, 4'b1000,   1};
        vecs[8]  = '{4'b0110,   3, 1'b1, 1'b0, 4'b0010,   3};
        vecs[9]  = '{4'b0100,   0, 1'b0, 1'b0, 4'b0100,   3};
        vecs[10] = '{4'b1011,   2, 1'b1, 1'b0, 4'b1000,   2};
        vecs[11] = '{4'b1011,   2, 1'b1, 1'b0, 4'b0001,   2};
        vecs[12] = '{4'b1010,   7, 1'b0, 1'b1, 4'b0010,   2};

        rst = 1'b1;
        req = '0;
        array_done  = 1'b0;
        array_valid = 1'b0;
        mdl_last = NUM_REQ - 1;
        mdl_lat  = 0;
        step();
        step();
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset sel", 32'(sel), 32'd0);
        chk("reset pulses", 32'({job_done, job_error}), 32'd0);
        chk("reset start", 32'(array_start), 32'd0);
        chk("reset rst_n", 32'(array_rst_n), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset latency", 32'(last_latency), 32'd0);
        rst = 1'b0;
        step();
        chk("post-reset rst_n", 32'(array_rst_n), 32'd1);
        chk("post-reset busy", 32'(busy), 32'd0);

        for (int v = 0; v < 13; v++) begin
            run_job(vecs[v].req, vecs[v].delay, vecs[v].valid, vecs[v].drop,
                    vecs[v].exp_grant, vecs[v].exp_lat, $sformatf("vec%0d", v));
        end

        // Stray array_done while idle must not start or finish anything.
        req = '0;
        array_done  = 1'b1;
        array_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stray busy", 32'(busy), 32'd0);
            chk("stray outputs", 32'({grant, job_done, job_error, 3'b0, array_start}), 32'd0);
        end
        array_done  = 1'b0;
        array_valid = 1'b0;
        chk("stray latency", 32'(last_latency), 32'(mdl_lat));

        // Reset in the middle of RUN aborts with no pulse.
        req = 4'b0010;
        step();
        chk("midrst grant", 32'(grant), 32'b0010);
        repeat (5) step();
        chk("midrst running", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = '0;
        chk("midrst outputs", 32'({grant, job_done, job_error, 3'b0, array_start, busy}), 32'd0);
        chk("midrst rst_n", 32'(array_rst_n), 32'd0);
        chk("midrst latency", 32'(last_latency), 32'd0);
        step();
        chk("midrst after pulses", 32'({job_done, job_error}), 32'd0);
        chk("midrst after rst_n", 32'(array_rst_n), 32'd1);
        mdl_last = NUM_REQ - 1;
        mdl_lat  = 0;

        for (int n = 0; n < 40; n++) begin
            logic [3:0] r;
            int         d;
            bit         vl;
            bit         dr;
            int         w;
            r  = 4'($urandom_range(1, 15));
            d  = $urandom_range(1, 20);
            vl = ($urandom_range(0, 3) != 0);
            dr = 1'($urandom_range(0, 1));
            w  = rr_winner(r, mdl_last);
            if ($urandom_range(0, 4) == 0) begin
                req = '0;
                repeat ($urandom_range(1, 3)) step();
            end
            run_job(r, d, vl, dr, 4'(1 << w), vl ? d : mdl_lat, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_job_arbiter.md
SYSTOLIC_JOB_ARBITER -- requirements
Module: systolic_job_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one systolic_array_top.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000, maximum RUN cycles allowed before a job is aborted.
REQ-003 SHALL have parameter LAT_W, default 16, width of the latency report.
REQ-004 Ports, one per line; the clock and reset ports are fixed as stated:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester job request, level.
- grant  out  NUM_REQ  one-hot owner of the array, zero when idle.
- sel  out  clog2(NUM_REQ)  operand/result mux select, index of the granted requester.
- job_done  out  NUM_REQ  one-cycle pulse to the owner on successful completion.
- job_error  out  NUM_REQ  one-cycle pulse to the owner on timeout or invalid result.
- array_start  out  1  one-cycle start pulse to the array.
- array_rst_n  out  1  active-low reset to the array, driven low for recovery.
- array_done  in  1  array computation_done.
- array_valid  in  1  array result_valid.
- busy  out  1  high in any state other than IDLE.
- last_latency  out  LAT_W  RUN cycle count of the most recent successful job.

Function
REQ-005 SHALL implement FSM states IDLE, GRANT, RUN, DONE, ERR; all outputs SHALL be registered.
REQ-006 IDLE: if any req bit is high, SHALL pick the winner round-robin, searching from index (last_winner+1) mod NUM_REQ upward; SHALL go to GRANT on the next edge.
REQ-007 IDLE with req==0 SHALL stay in IDLE, with grant=0 and array_start=0.
REQ-008 GRANT SHALL last exactly 1 cycle with grant[w]=1, sel=w and array_start=1; SHALL then go to RUN.
REQ-009 Latency: req sampled high at edge n -> grant and array_start high in cycle n+1.
REQ-010 RUN SHALL clear the cycle counter on entry, then count RUN cycles including the cycle in which array_done is seen.
REQ-011 In RUN, when array_done=1 and array_valid=1, the FSM SHALL go to DONE and load last_latency with the counter value, saturating at 2^LAT_W-1.
REQ-012 In RUN, when array_done=1 and array_valid=0, the FSM SHALL go to ERR; this is treated as an invalid result.
REQ-013 In RUN, when the counter reaches TIMEOUT_CYCLES with array_done=0, the FSM SHALL go to ERR.
REQ-014 DONE SHALL last 1 cycle with job_done[w]=1 and grant[w] still held; last_winner SHALL update to w, and the FSM SHALL return to IDLE.
REQ-015 ERR SHALL last exactly 2 cycles:
- job_error[w]=1 in the first cycle only.
- array_rst_n=0 in both cycles.
- grant[w] held in both cycles.
- last_winner updates to w; last_latency is unchanged.
- FSM then returns to IDLE.
REQ-016 grant SHALL remain constant from GRANT through DONE/ERR; deasserting req mid-job SHALL NOT cancel the job.
REQ-017 array_done seen in IDLE, GRANT, DONE or ERR SHALL be ignored.
REQ-018 A requester holding req high after its done/error SHALL be re-arbitrated only in the next IDLE cycle, so back-to-back jobs have one IDLE cycle between them.
REQ-019 With all req bits high, grants SHALL rotate 0,1,2,3,0,...; no requester SHALL wait more than NUM_REQ-1 jobs.
REQ-020 Counter width SHALL be sufficient to hold TIMEOUT_CYCLES without wrap.

Reset
REQ-021 With rst=1 at an edge, the block SHALL enter IDLE with:
- grant=0, sel=0
- job_done=0, job_error=0
- array_start=0, array_rst_n=0, busy=0
- last_latency=0
- last_winner=NUM_REQ-1, so requester 0 has priority first.
REQ-022 array_rst_n SHALL go to 1 in the first cycle after rst is released, except in ERR.
REQ-023 rst asserted mid-job SHALL abort with no job_done or job_error pulse; the array is held in reset by array_rst_n=0.

Verification
REQ-024 Single job: req=0001, array_done and array_valid driven high 130 cycles after start -> grant=0001 and one array_start pulse one cycle after req; job_done=0001 for one cycle; last_latency=130.
REQ-025 Contention: req=1111 held, every job completes in 10 cycles -> grant sequence 0001,0010,0100,1000,0001; exactly one array_start per job.
REQ-026 Timeout: req=0100, array_done held 0 -> job_error=0100 for one cycle after 10000 RUN cycles; array_rst_n low for 2 cycles; last_latency unchanged; then IDLE.
REQ-027 Invalid result: array_done=1 with array_valid=0 -> ERR path with job_error pulse; no job_done.
REQ-028 Mid-job events:
- Stray array_done in IDLE is ignored.
- Dropping req in RUN still yields job_done.
- rst mid-RUN -> all outputs at reset values on the next cycle, with no pulses.
